// File: rtl/bram_stream_reader_pkg.sv
// Shared types and width helpers for the blocks that talk to bram_wrapper.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    function automatic int addr_size(input int addrs);
        return $clog2(addrs);
    endfunction

    // One extra bit so a full-depth burst (count == ADDRS) is representable.
    function automatic int cnt_size(input int addrs);
        return $clog2(addrs) + 1;
    endfunction

    function automatic int word_width(input int pieces, input int bram_width);
        return pieces * bram_width;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Command, wrapper-handshake and output-stream bundle of bram_stream_reader.
// Optional m_last_out is present when BRAM_STREAM_LAST_EN is defined.
interface bram_stream_reader_if
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDRS      = 1024,
    parameter int BRAM_WIDTH = 64,
    parameter int PIECES     = 32
) ();

    localparam int ADDR_SIZE = addr_size(ADDRS);
    localparam int CNT_SIZE  = cnt_size(ADDRS);
    localparam int WIDTH     = word_width(PIECES, BRAM_WIDTH);

    logic                 start_in;
    logic [ADDR_SIZE-1:0] base_addr_in;
    logic [CNT_SIZE-1:0]  count_in;
    logic                 busy_out;
    logic                 done_out;
    logic [ADDR_SIZE-1:0] wr_addr_out;
    logic                 wr_read_en_out;
    logic [WIDTH-1:0]     wr_data_in;
    logic                 wr_finished_in;
    logic [WIDTH-1:0]     m_data_out;
    logic                 m_valid_out;
    logic                 m_ready_in;
`ifdef BRAM_STREAM_LAST_EN
    logic                 m_last_out;
`endif

    // slave: the reader itself; master: the host/wrapper/consumer side.
    modport slave (
        input  start_in, base_addr_in, count_in, wr_data_in, wr_finished_in, m_ready_in,
        output busy_out, done_out, wr_addr_out, wr_read_en_out, m_data_out, m_valid_out
`ifdef BRAM_STREAM_LAST_EN
        , output m_last_out
`endif
    );

    modport master (
        output start_in, base_addr_in, count_in, wr_data_in, wr_finished_in, m_ready_in,
        input  busy_out, done_out, wr_addr_out, wr_read_en_out, m_data_out, m_valid_out
`ifdef BRAM_STREAM_LAST_EN
        , input m_last_out
`endif
    );

endinterface

// File: rtl/bram_stream_reader_fifo.sv
// Small synchronous FIFO; head entry is read straight from registered storage,
// so a pushed word is visible one cycle after the push edge.
module bram_stream_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] entries [DEPTH];
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);
    // When full, a push is only taken if the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_ok);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q;

        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                entry_q <= '0;
            end else if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                entry_q <= push_data_i;
            end
        end

        assign entries[gi] = entry_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o = entries[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Burst sequencer in front of bram_wrapper: one wide read in flight at a time,
// results buffered and streamed out. BRAM_STREAM_LAST_EN adds a last-beat tag.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDRS      = 1024,
    parameter int BRAM_WIDTH = 64,
    parameter int PIECES     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    bram_stream_reader_if.slave bus
);

    localparam int ADDR_SIZE = addr_size(ADDRS);
    localparam int CNT_SIZE  = cnt_size(ADDRS);
    localparam int WIDTH     = word_width(PIECES, BRAM_WIDTH);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1;
`ifdef BRAM_STREAM_LAST_EN
    localparam int FIFO_W    = WIDTH + 1;
`else
    localparam int FIFO_W    = WIDTH;
`endif

    state_t               state_q;
    logic [ADDR_SIZE-1:0] cur_addr_q;
    logic [CNT_SIZE-1:0]  remaining_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 wait_first_q;

    logic                 issue_fire;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [FCNT_W-1:0]    fifo_count;
    logic [FIFO_W-1:0]    fifo_push_data;
    logic [FIFO_W-1:0]    fifo_head;

    assign issue_fire = (state_q == ST_ISSUE) && (fifo_count != FCNT_W'(FIFO_DEPTH));
    // The wrapper's finished flag is stale in the first WAIT cycle, so it is skipped.
    assign fifo_push  = (state_q == ST_WAIT) && !wait_first_q && bus.wr_finished_in;
    assign fifo_pop   = bus.m_valid_out && bus.m_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start_in && !done_q) begin
                        cur_addr_q  <= bus.base_addr_in;
                        remaining_q <= bus.count_in;
                        busy_q      <= 1'b1;
                        state_q     <= (bus.count_in == '0) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_fire) begin
                        wait_first_q <= 1'b1;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (bus.wr_finished_in) begin
                        cur_addr_q  <= cur_addr_q + ADDR_SIZE'(1);
                        remaining_q <= remaining_q - CNT_SIZE'(1);
                        state_q     <= (remaining_q == CNT_SIZE'(1)) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef BRAM_STREAM_LAST_EN
    assign fifo_push_data = {remaining_q == CNT_SIZE'(1), bus.wr_data_in};
    assign bus.m_data_out = fifo_head[WIDTH-1:0];
    assign bus.m_last_out = fifo_head[WIDTH];
`else
    assign fifo_push_data = bus.wr_data_in;
    assign bus.m_data_out = fifo_head;
`endif

    bram_stream_reader_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_data_o (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.m_valid_out    = !fifo_empty;
    assign bus.busy_out       = busy_q;
    assign bus.done_out       = done_q;
    assign bus.wr_addr_out    = cur_addr_q;
    assign bus.wr_read_en_out = issue_fire;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader with a behavioural bram_wrapper stand-in
// (PIECES=4, ADDRS=16); expected beats come from word k = k*0x1111.
module tb_bram_stream_reader;

    localparam int ADDRS  = 16;
    localparam int PIECES = 4;
    localparam int BW     = 64;
    localparam int FD     = 2;
    localparam int W      = PIECES * BW;
    localparam int AS     = $clog2(ADDRS);
    localparam int CS     = AS + 1;
    localparam int LAT    = 2 * PIECES + 3;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_stream_reader_if #(.ADDRS(ADDRS), .BRAM_WIDTH(BW), .PIECES(PIECES)) bus ();

    bram_stream_reader #(
        .ADDRS      (ADDRS),
        .BRAM_WIDTH (BW),
        .PIECES     (PIECES),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    int            ready_mode  = 1;   // 0: never ready, 1: always ready, 2: random
    int            done_cnt    = 0;
    int            overlap_cnt = 0;
    logic [W-1:0]  beats    [$];
    logic          lasts    [$];
    logic [AS-1:0] rd_addrs [$];
    logic          hold_pending = 1'b0;
    logic [W-1:0]  held_data;

    logic [W-1:0]  bram [ADDRS];
    logic          wr_busy;
    int            wr_timer;
    logic [AS-1:0] wr_lat;

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input int base, input int i);
        int a;
        a = (base + i) % ADDRS;
        return W'(a * 32'h1111);
    endfunction

    // Wrapper stand-in: one read at a time, finished pulse LAT cycles after issue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_finished_in <= 1'b0;
            bus.wr_data_in     <= '0;
            wr_busy            <= 1'b0;
            wr_timer           <= 0;
            wr_lat             <= '0;
        end else begin
            bus.wr_finished_in <= 1'b0;
            if (wr_busy) begin
                if (wr_timer == 1) begin
                    bus.wr_finished_in <= 1'b1;
                    bus.wr_data_in     <= bram[wr_lat];
                    wr_busy            <= 1'b0;
                end
                wr_timer <= wr_timer - 1;
            end
            if (bus.wr_read_en_out) begin
                if (wr_busy) overlap_cnt <= overlap_cnt + 1;
                wr_busy  <= 1'b1;
                wr_timer <= LAT;
                wr_lat   <= bus.wr_addr_out;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.m_ready_in = 1'b0;
            1:       bus.m_ready_in = 1'b1;
            default: bus.m_ready_in = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream/wrapper monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                check("stream_hold", {bus.m_valid_out, bus.m_data_out}, {1'b1, held_data});
            hold_pending = bus.m_valid_out && !bus.m_ready_in;
            held_data    = bus.m_data_out;
            if (bus.m_valid_out && bus.m_ready_in) begin
                beats.push_back(bus.m_data_out);
`ifdef BRAM_STREAM_LAST_EN
                lasts.push_back(bus.m_last_out);
`endif
            end
            if (bus.wr_read_en_out) rd_addrs.push_back(bus.wr_addr_out);
            if (bus.done_out) done_cnt++;
        end
    end

    task automatic clear_logs();
        beats.delete();
        lasts.delete();
        rd_addrs.delete();
        done_cnt = 0;
    endtask

    task automatic start_burst(input int base, input int count);
        clear_logs();
        @(posedge clk); #1;
        bus.start_in     = 1'b1;
        bus.base_addr_in = AS'(base);
        bus.count_in     = CS'(count);
        @(posedge clk); #1;
        bus.start_in     = 1'b0;
    endtask

    task automatic finish_burst(input string tag, input int base, input int count);
        int c;
        c = 0;
        while (done_cnt == 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, W'(done_cnt), W'(1));
        check({tag, "_busy"}, W'(bus.busy_out), W'(0));
        check({tag, "_nbeats"}, W'(beats.size()), W'(count));
        check({tag, "_nreads"}, W'(rd_addrs.size()), W'(count));
        for (int i = 0; i < beats.size() && i < count; i++)
            check($sformatf("%s_beat%0d", tag, i), {1'b0, beats[i]}, {1'b0, exp_word(base, i)});
        for (int i = 0; i < rd_addrs.size() && i < count; i++)
            check($sformatf("%s_addr%0d", tag, i), W'(rd_addrs[i]), W'((base + i) % ADDRS));
`ifdef BRAM_STREAM_LAST_EN
        for (int i = 0; i < lasts.size() && i < count; i++)
            check($sformatf("%s_last%0d", tag, i), W'(lasts[i]), W'(i == count - 1));
`endif
        check({tag, "_overlap"}, W'(overlap_cnt), W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int k = 0; k < ADDRS; k++) bram[k] = W'(k * 32'h1111);
        bus.start_in     = 1'b0;
        bus.base_addr_in = '0;
        bus.count_in     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  W'(bus.busy_out), W'(0));
        check("rst_done",  W'(bus.done_out), W'(0));
        check("rst_rden",  W'(bus.wr_read_en_out), W'(0));
        check("rst_addr",  W'(bus.wr_addr_out), W'(0));
        check("rst_valid", W'(bus.m_valid_out), W'(0));
        check("rst_data",  {1'b0, bus.m_data_out}, W'(0));
        rst_n = 1'b1;

        // Basic burst
        ready_mode = 1;
        start_burst(3, 4);
        finish_burst("basic", 3, 4);

        // Zero-length burst, then a start landing on the done pulse
        clear_logs();
        @(posedge clk); #1;
        bus.start_in = 1'b1; bus.base_addr_in = AS'(7); bus.count_in = '0;
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        check("cnt0_done_early", W'(bus.done_out), W'(0));
        check("cnt0_busy_early", W'(bus.busy_out), W'(1));
        @(posedge clk); #1;
        check("cnt0_done", W'(bus.done_out), W'(1));
        check("cnt0_busy", W'(bus.busy_out), W'(0));
        bus.start_in = 1'b1; bus.base_addr_in = '0; bus.count_in = CS'(2);
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        check("done_start_ignored", W'(bus.busy_out), W'(0));
        repeat (5) @(posedge clk);
        #1;
        check("cnt0_nreads", W'(rd_addrs.size()), W'(0));
        check("cnt0_nbeats", W'(beats.size()), W'(0));
        check("cnt0_ndone", W'(done_cnt), W'(1));

        // Address wrap
        start_burst(14, 4);
        finish_burst("wrap", 14, 4);

        // Back-pressure: FIFO fills, ISSUE stalls, then drains
        ready_mode = 0;
        start_burst(0, 5);
        repeat (80) @(posedge clk);
        #1;
        check("stall_nreads", W'(rd_addrs.size()), W'(FD));
        check("stall_nbeats", W'(beats.size()), W'(0));
        check("stall_valid",  W'(bus.m_valid_out), W'(1));
        check("stall_busy",   W'(bus.busy_out), W'(1));
        check("stall_head",   {1'b0, bus.m_data_out}, {1'b0, exp_word(0, 0)});
        ready_mode = 1;
        finish_burst("stall", 0, 5);

        // Reset in the WAIT of the second word
        ready_mode = 0;
        start_burst(5, 4);
        c = 0;
        while (rd_addrs.size() < 2 && c < 300) begin
            @(posedge clk);
            c++;
        end
        check("midrst_reached", W'(rd_addrs.size() >= 2), W'(1));
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  W'(bus.busy_out), W'(0));
        check("midrst_done",  W'(bus.done_out), W'(0));
        check("midrst_rden",  W'(bus.wr_read_en_out), W'(0));
        check("midrst_addr",  W'(bus.wr_addr_out), W'(0));
        check("midrst_valid", W'(bus.m_valid_out), W'(0));
        check("midrst_data",  {1'b0, bus.m_data_out}, W'(0));
        repeat (2) @(posedge clk);
        #1;
        check("midrst_nodone", W'(done_cnt), W'(0));
        rst_n = 1'b1;
        ready_mode = 1;
        start_burst(5, 4);
        finish_burst("after_rst", 5, 4);

        // Start while busy is ignored
        ready_mode = 2;
        start_burst(2, 3);
        repeat (5) @(posedge clk);
        #1;
        bus.start_in = 1'b1; bus.base_addr_in = AS'(9); bus.count_in = CS'(7);
        @(posedge clk); #1;
        bus.start_in = 1'b0;
        finish_burst("busy_start", 2, 3);

        // Random bursts with random back-pressure
        for (int i = 0; i < 5; i++) begin
            int b;
            int n;
            b = int'($urandom_range(0, ADDRS - 1));
            n = int'($urandom_range(0, ADDRS));
            start_burst(b, n);
            finish_burst($sformatf("rand%0d", i), b, n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
